score_tick_ctrl: RTL and testbench

//  Game-score sequencer for the VGA score display. Owns the game state FSM (IDLE/RUN/PAUSE/OVER),
//  the level-dependent score-tick divider and the binary score register. Hands each new score to
//  the binary-to-BCD converter over a req/ack handshake. Sits between game logic and the BCD/VGA path.

---
 rtl/score_pkg.sv | 32 +++
 rtl/score_conv_hs.sv | 33 +++
 rtl/score_tick_ctrl.sv | 113 +++++++++++
 tb/tb_score_tick_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score tick controller: game states, level thresholds
// and the score-to-level mapping.
package score_pkg;

   localparam int unsigned SCORE_W    = 14;
   localparam int unsigned LEVEL_W    = 3;
   localparam int unsigned NUM_LEVELS = 6;

   // Upper score bound of each level (level 0 ends below LVL1_MIN)
   localparam int unsigned LVL1_MIN = 15;
   localparam int unsigned LVL1_MAX = 30;
   localparam int unsigned LVL2_MAX = 50;
   localparam int unsigned LVL3_MAX = 100;
   localparam int unsigned LVL4_MAX = 1000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   function automatic logic [LEVEL_W-1:0] level_of(input logic [SCORE_W-1:0] s);
      if (s > SCORE_W'(LVL4_MAX))       return LEVEL_W'(NUM_LEVELS - 1);
      else if (s > SCORE_W'(LVL3_MAX))  return LEVEL_W'(4);
      else if (s > SCORE_W'(LVL2_MAX))  return LEVEL_W'(3);
      else if (s > SCORE_W'(LVL1_MAX))  return LEVEL_W'(2);
      else if (s >= SCORE_W'(LVL1_MIN)) return LEVEL_W'(1);
      else                              return LEVEL_W'(0);
   endfunction

endpackage

// File: rtl/score_conv_hs.sv
// Req/ack handshake toward the binary-to-BCD converter. Snapshots the score on request and
// remembers at most one newer change while a request is outstanding.
module score_conv_hs
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               update,
   input  logic [SCORE_W-1:0] score,
   input  logic               conv_ack,
   output logic               conv_req,
   output logic [SCORE_W-1:0] conv_data
);

   logic pending;

   // conv_data only loads while conv_req is low, so it is stable for the whole request
   always_ff @(posedge clk) begin
      if (reset) begin
         conv_req  <= 1'b0;
         conv_data <= '0;
         pending   <= 1'b0;
      end else if (conv_req) begin
         if (conv_ack) conv_req <= 1'b0;
         if (update)   pending  <= 1'b1;
      end else if (update || pending) begin
         conv_req  <= 1'b1;
         conv_data <= score;
         pending   <= 1'b0;
      end
   end

endmodule

// File: rtl/score_tick_ctrl.sv
// Game-score sequencer: game state FSM, level-dependent tick divider, saturating score and
// converter handshake. Define SCORE_HISCORE_EN to build the high_score register.
module score_tick_ctrl
   import score_pkg::*;
#(
   parameter int unsigned BASE_DIV  = 50_000_000,
   parameter int unsigned SCORE_MAX = 9999
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               stop_temp,
   input  logic               conv_ack,
   output logic [SCORE_W-1:0] score_bin,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         state,
   output logic               tick,
   output logic               conv_req,
   output logic [SCORE_W-1:0] conv_data,
   output logic [SCORE_W-1:0] high_score
);

   localparam int unsigned CNT_W = $clog2(BASE_DIV + 1);

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_last;
   logic             cnt_hit;
   logic             at_max;
   logic             run_cnt;
   logic             enter_over;
   logic             score_upd;

   assign state = st;

   // Divider compare and the conditions that end a game this cycle
   always_comb begin
      div_last   = (CNT_W'(BASE_DIV) >> level) - CNT_W'(1);
      cnt_hit    = (cnt >= div_last);
      at_max     = (score_bin == SCORE_W'(SCORE_MAX));
      run_cnt    = (st == ST_RUN) && !stop_temp && !pause;
      enter_over = (((st == ST_RUN) || (st == ST_PAUSE)) && stop_temp)
                 || (run_cnt && cnt_hit && at_max);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= ST_IDLE;
         score_bin <= '0;
         level     <= '0;
         cnt       <= '0;
         tick      <= 1'b0;
         score_upd <= 1'b0;
      end else begin
         tick      <= 1'b0;
         score_upd <= 1'b0;
         level     <= level_of(score_bin);

         case (st)
            ST_IDLE, ST_OVER: begin
               if (start && !stop_temp) begin
                  st        <= ST_RUN;
                  score_bin <= '0;
                  cnt       <= '0;
                  level     <= '0;
                  score_upd <= 1'b1;
               end
            end
            ST_RUN:   if (pause && !stop_temp)  st <= ST_PAUSE;
            ST_PAUSE: if (!pause && !stop_temp) st <= ST_RUN;
            default:  st <= ST_IDLE;
         endcase

         if (enter_over) st <= ST_OVER;

         // Counter holds outside RUN; a saturated hit leaves everything frozen
         if (run_cnt) begin
            if (!cnt_hit) begin
               cnt <= cnt + CNT_W'(1);
            end else if (!at_max) begin
               tick      <= 1'b1;
               cnt       <= '0;
               score_bin <= score_bin + SCORE_W'(1);
               score_upd <= 1'b1;
            end
         end
      end
   end

`ifdef SCORE_HISCORE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         high_score <= '0;
      end else if (enter_over && (score_bin > high_score)) begin
         high_score <= score_bin;
      end
   end
`else
   assign high_score = '0;
`endif

   score_conv_hs u_conv_hs (
      .clk       (clk),
      .reset     (reset),
      .update    (score_upd),
      .score     (score_bin),
      .conv_ack  (conv_ack),
      .conv_req  (conv_req),
      .conv_data (conv_data)
   );

endmodule

// File: tb/tb_score_tick_ctrl.sv
// Directed self-checking bench for score_tick_ctrl with BASE_DIV=64 (DIV_L = 64,32,16,8,4,2).
module tb_score_tick_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, pause, stop_temp;
   logic        conv_ack = 1'b0;
   logic [13:0] score_bin, conv_data, high_score;
   logic [2:0]  level;
   logic [1:0]  state;
   logic        tick, conv_req;

   int   n_checks = 0;
   int   n_errs   = 0;
   logic auto_ack = 1'b1;
   logic ack_force = 1'b0;
   int   req_rises = 0;
   logic req_prev = 1'b0;

`ifdef SCORE_HISCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   score_tick_ctrl #(.BASE_DIV(64), .SCORE_MAX(9999)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .stop_temp  (stop_temp),
      .conv_ack   (conv_ack),
      .score_bin  (score_bin),
      .level      (level),
      .state      (state),
      .tick       (tick),
      .conv_req   (conv_req),
      .conv_data  (conv_data),
      .high_score (high_score)
   );

   // Converter model: one-cycle ack per request in auto mode, else driven by ack_force
   always @(negedge clk) begin
      conv_ack = auto_ack ? (conv_req && !conv_ack) : ack_force;
      if (conv_req === 1'b1 && req_prev === 1'b0) req_rises++;
      req_prev = conv_req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (tick !== 1'b1 && n < limit);
      if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 32'd1);
   endtask

   function automatic int lvl_exp(input int s);
      case (s)
         30, 15:    return 1;
         31, 50:    return 2;
         51, 100:   return 3;
         101, 1000: return 4;
         1001:      return 5;
         default:   return -1;
      endcase
   endfunction

   initial begin
      int n, ticks, r0, cyc, e, guard;
      reset = 1'b1; start = 1'b0; pause = 1'b0; stop_temp = 1'b0;
      step(); step();

      chk("rst_state", 32'(state), 0);
      chk("rst_score", 32'(score_bin), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_req", 32'(conv_req), 0);
      chk("rst_data", 32'(conv_data), 0);
      chk("rst_hiscore", 32'(high_score), 0);
      reset = 1'b0;
      step();

      // Start, first tick after 64 cycles, request one cycle later
      start = 1'b1; step(); start = 1'b0;
      chk("start_run", 32'(state), 1);
      wait_tick(200, n);
      chk("first_tick_lat", 32'(n), 64);
      chk("score_1", 32'(score_bin), 1);
      step();
      chk("req_after_tick", 32'(conv_req), 1);
      chk("data_1", 32'(conv_data), 1);

      // Pause at cnt=20 for 100 cycles, resume needs 44 more run cycles
      repeat (19) step();
      pause = 1'b1; step();
      chk("pause_state", 32'(state), 2);
      ticks = 0;
      repeat (100) begin step(); if (tick === 1'b1) ticks++; end
      chk("pause_no_tick", 32'(ticks), 0);
      pause = 1'b0; step();
      chk("resume_state", 32'(state), 1);
      wait_tick(200, n);
      chk("resume_lat", 32'(n), 44);
      chk("score_2", 32'(score_bin), 2);

      // Level 1 at score 15, ticks then 32 apart
      guard = 0;
      while (score_bin != 14'd15 && guard < 20) begin wait_tick(100, n); guard++; end
      chk("score_15", 32'(score_bin), 15);
      chk("lvl_at_tick15", 32'(level), 0);
      step();
      chk("lvl_after15", 32'(level), 1);
      wait_tick(100, n);
      chk("l1_spacing_a", 32'(n + 1), 32);
      wait_tick(100, n);
      chk("l1_spacing_b", 32'(n), 32);
      chk("score_17", 32'(score_bin), 17);

      // Ack withheld across three ticks, then a single catch-up request
      auto_ack = 1'b0;
      step();
      chk("hold_req", 32'(conv_req), 1);
      chk("hold_data", 32'(conv_data), 17);
      for (int k = 0; k < 3; k++) begin
         wait_tick(100, n);
         chk($sformatf("frozen_data_%0d", k), 32'(conv_data), 17);
         chk($sformatf("frozen_req_%0d", k), 32'(conv_req), 1);
      end
      r0 = req_rises;
      ack_force = 1'b1; step();
      chk("req_drop", 32'(conv_req), 0);
      ack_force = 1'b0; step();
      chk("req_reraise", 32'(conv_req), 1);
      chk("data_latest", 32'(conv_data), 20);
      auto_ack = 1'b1;
      repeat (4) step();
      chk("extra_reqs", 32'(req_rises - r0), 1);
      chk("req_idle", 32'(conv_req), 0);

      // stop_temp beats pause; restart clears score
      stop_temp = 1'b1; pause = 1'b1; step();
      chk("over_state", 32'(state), 3);
      stop_temp = 1'b0; pause = 1'b0; step();
      chk("over_score", 32'(score_bin), 20);
      chk("hiscore_20", 32'(high_score), HS_EN ? 32'd20 : 32'd0);
      start = 1'b1; step(); start = 1'b0;
      chk("restart_state", 32'(state), 1);
      chk("restart_score", 32'(score_bin), 0);
      chk("restart_level", 32'(level), 0);
      step();
      chk("restart_req", 32'(conv_req), 1);
      chk("restart_data", 32'(conv_data), 0);

      // Run to saturation, checking level boundaries on the way
      cyc = 0;
      while (score_bin != 14'd9999 && cyc < 60000) begin
         step(); cyc++;
         if (tick === 1'b1) begin
            e = lvl_exp(int'(score_bin));
            if (e >= 0) begin
               step(); cyc++;
               chk($sformatf("level_s%0d", score_bin), 32'(level), 32'(e));
            end
         end
      end
      chk("sat_reached", 32'(score_bin), 9999);
      ticks = 0;
      repeat (10) begin step(); if (tick === 1'b1) ticks++; end
      chk("sat_no_tick", 32'(ticks), 0);
      chk("sat_state", 32'(state), 3);
      chk("sat_score", 32'(score_bin), 9999);
      chk("sat_level", 32'(level), 5);
      chk("hiscore_max", 32'(high_score), HS_EN ? 32'd9999 : 32'd0);

      // Reset while a request is outstanding
      auto_ack = 1'b0; ack_force = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("pre_rst_req", 32'(conv_req), 1);
      reset = 1'b1; step();
      chk("mid_rst_state", 32'(state), 0);
      chk("mid_rst_score", 32'(score_bin), 0);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_tick", 32'(tick), 0);
      chk("mid_rst_req", 32'(conv_req), 0);
      chk("mid_rst_data", 32'(conv_data), 0);
      chk("mid_rst_hiscore", 32'(high_score), 0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
